// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, the bubble word and the fetch FSM state type.
package cpu_pkg;

    localparam logic [4:0]  OP_HALT  = 5'b00000;
    localparam logic [4:0]  OP_NOP   = 5'b00001;
    localparam logic [4:0]  OP_JAL   = 5'b11000;
    localparam logic [4:0]  OP_JALR  = 5'b11001;

    localparam logic [15:0] NOP_WORD = 16'h0800;
    localparam logic [15:0] PC_RESET = 16'h0000;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2,
        HALT    = 2'd3
    } fetch_state_t;

    // Sequential PC step; 16-bit arithmetic wraps 16'hFFFE -> 16'h0000.
    function automatic logic [15:0] pc_inc(input logic [15:0] i_pc);
        return i_pc + 16'd2;
    endfunction

endpackage

// File: rtl/ifid_skid.sv
// One-entry skid buffer catching an instruction that completes while decode is stalled.
module ifid_skid (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_drain,
    input  logic        i_clear,
    input  logic [15:0] i_ins,
    input  logic [15:0] i_pc2,
    output logic [15:0] o_ins,
    output logic [15:0] o_pc2,
    output logic        o_full
);

    logic        r_full;
    logic [15:0] r_ins;
    logic [15:0] r_pc2;

    always_ff @(posedge clk) begin
        if (rst || i_clear)
            r_full <= 1'b0;
        else if (i_load)
            r_full <= 1'b1;
        else if (i_drain)
            r_full <= 1'b0;
    end

    // Payload carries no reset; it is only observed while r_full is set.
    always_ff @(posedge clk) begin
        if (i_load) begin
            r_ins <= i_ins;
            r_pc2 <= i_pc2;
        end
    end

    assign o_ins  = r_ins;
    assign o_pc2  = r_pc2;
    assign o_full = r_full;

endmodule

// File: rtl/fetch_ifid_ctrl.sv
// Fetch-stage controller: owns the PC, talks to a req/done instruction memory and
// holds the IF/ID latch, honouring stall/flush from the hazard unit and stopping on HALT.
module fetch_ifid_ctrl
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = PC_RESET,
    parameter logic [15:0] NOP_INS  = NOP_WORD,
    parameter logic [4:0]  HALT_OP  = OP_HALT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_decode,
    input  logic        flush_fetch,
    input  logic [15:0] branch_target,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_done,
    output logic [15:0] if_id_ins,
    output logic [15:0] if_id_pc2,
    output logic        if_id_valid,
    output logic [15:0] pc,
    output logic        halted
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;

    logic [15:0] r_pc;
    logic [15:0] r_ins;
    logic [15:0] r_pc2;
    logic        r_vld;
    logic        r_halted;
    logic [15:0] r_kill_addr;

    logic        w_skid_full;
    logic [15:0] w_skid_ins;
    logic [15:0] w_skid_pc2;

    logic        w_req_fetch;
    logic        w_accept;
    logic        w_outstanding;
    logic        w_drain;
    logic        w_skid_load;
    logic        w_load_ifid;
    logic [15:0] w_new_ins;
    logic [15:0] w_new_pc2;
    logic        w_is_halt;

    // A new request leaves FETCH only when decode can take it and the skid is free.
    assign w_req_fetch   = (r_state == FETCH) && !stall_decode && !w_skid_full;
    assign w_accept      = imem_done && (w_req_fetch || (r_state == WAIT));
    assign w_outstanding = !imem_done &&
                           (w_req_fetch || (r_state == WAIT) || (r_state == DISCARD));
    assign w_drain       = (r_state == FETCH) && w_skid_full && !stall_decode && !flush_fetch;
    assign w_skid_load   = w_accept && stall_decode && !flush_fetch;
    assign w_load_ifid   = ((w_accept && !stall_decode) || w_drain) && !flush_fetch;
    assign w_new_ins     = w_drain ? w_skid_ins : imem_data;
    assign w_new_pc2     = w_drain ? w_skid_pc2 : pc_inc(r_pc);
    assign w_is_halt     = (w_new_ins[15:11] == HALT_OP);

    always_comb begin
        imem_rd   = 1'b0;
        imem_addr = r_pc;
        case (r_state)
            FETCH:   imem_rd = w_req_fetch;
            WAIT:    imem_rd = 1'b1;
            DISCARD: begin
                imem_rd   = 1'b1;
                imem_addr = r_kill_addr;
            end
            default: imem_rd = 1'b0;
        endcase
        if (rst)
            imem_rd = 1'b0;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush_fetch) begin
            w_state_nxt = w_outstanding ? DISCARD : FETCH;
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_load_ifid && w_is_halt)
                        w_state_nxt = HALT;
                    else if (w_req_fetch && !imem_done)
                        w_state_nxt = WAIT;
                end
                WAIT: begin
                    if (imem_done)
                        w_state_nxt = (w_load_ifid && w_is_halt) ? HALT : FETCH;
                end
                DISCARD: begin
                    if (imem_done)
                        w_state_nxt = FETCH;
                end
                default: w_state_nxt = HALT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= FETCH;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_ins    <= NOP_INS;
            r_pc2    <= 16'h0000;
            r_vld    <= 1'b0;
            r_halted <= 1'b0;
        end else if (flush_fetch) begin
            r_pc     <= branch_target;
            r_ins    <= NOP_INS;
            r_pc2    <= 16'h0000;
            r_vld    <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            if (w_accept)
                r_pc <= pc_inc(r_pc);
            if (w_load_ifid) begin
                r_ins <= w_new_ins;
                r_pc2 <= w_new_pc2;
                r_vld <= 1'b1;
                if (w_is_halt)
                    r_halted <= 1'b1;
            end else if ((r_state == HALT) && !stall_decode) begin
                r_ins <= NOP_INS;
                r_pc2 <= 16'h0000;
                r_vld <= 1'b0;
            end
        end
    end

    // Remember which address the killed access was on so DISCARD keeps it stable.
    always_ff @(posedge clk) begin
        if (flush_fetch && (r_state != DISCARD))
            r_kill_addr <= r_pc;
    end

    ifid_skid u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_drain (w_drain),
        .i_clear (flush_fetch),
        .i_ins   (imem_data),
        .i_pc2   (pc_inc(r_pc)),
        .o_ins   (w_skid_ins),
        .o_pc2   (w_skid_pc2),
        .o_full  (w_skid_full)
    );

    assign if_id_ins   = r_ins;
    assign if_id_pc2   = r_pc2;
    assign if_id_valid = r_vld;
    assign pc          = r_pc;
    assign halted      = r_halted;

endmodule
